// File: rtl/led_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// led_frame_scheduler_if
// Groups the scheduler's requester-side and driver-side signals.
//
// Handshakes:
//   requester side: req[i] is raised with req_data<i> stable and held until
//     ack[i] pulses for one cycle; the requester drops req[i] (or presents a
//     new frame) on the cycle after the ack.
//   driver side: frame_start pulses for one cycle with frame_data valid;
//     frame_data stays stable until the driver returns a one-cycle frame_done.
//
// Modports:
//   slave  : the scheduler (consumes req/req_data*/frame_done)
//   master : the environment (requesters plus serial driver)
// dbg_state mirrors the scheduler's FSM state register.
// ----------------------------------------------------------------------------
interface led_frame_scheduler_if #(
  parameter int NUM_LEDS = 6
) ();
  localparam int FW = 24 * NUM_LEDS;

  logic [1:0]    req;
  logic [FW-1:0] req_data0;
  logic [FW-1:0] req_data1;
  logic [1:0]    ack;
  logic [FW-1:0] frame_data;
  logic          frame_start;
  logic          frame_done;
  logic          busy;
  logic          cur_owner;
  logic [2:0]    dbg_state;

  modport slave (
    input  req, req_data0, req_data1, frame_done,
    output ack, frame_data, frame_start, busy, cur_owner, dbg_state
  );

  modport master (
    output req, req_data0, req_data1, frame_done,
    input  ack, frame_data, frame_start, busy, cur_owner, dbg_state
  );
endinterface

// File: rtl/led_frame_scheduler.sv
// ----------------------------------------------------------------------------
// led_frame_scheduler
// Arbitrates two frame requesters (0 = renderer, 1 = overlay) round-robin,
// latches the winning frame, hands it to the serial LED driver with a
// start/done handshake, enforces the latch gap after each frame and re-sends
// the held frame periodically while nobody requests.
//
// Ports:
//   sys_clk  : system clock
//   sys_rst  : asynchronous, active-high reset
//   bus      : led_frame_scheduler_if.slave
//              req/req_data0/req_data1/ack : requester handshake
//              frame_data/frame_start/frame_done : driver handshake
//              busy (not IDLE), cur_owner (source of held frame),
//              dbg_state (FSM state)
// ----------------------------------------------------------------------------
module led_frame_scheduler #(
  parameter int NUM_LEDS       = 6,
  parameter int GAP_CYCLES     = 2500,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  led_frame_scheduler_if.slave   bus
);
  localparam int FW = 24 * NUM_LEDS;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q;
  logic          owner_q;
  logic          rr_q;          // requester favoured on a tie
  logic          held_valid_q;  // a frame has been captured since reset
  logic [GW-1:0] gap_cnt_q;
  logic [RW-1:0] refresh_cnt_q; // IDLE cycles since the last frame_start
  logic          winner;
  logic          load_go;

  // Winner is the sole requester, or the rr-favoured one on a tie.
  always_comb begin
    winner = rr_q;
    case (bus.req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = rr_q;
    endcase
  end

  // A request withdrawn before its ack leaves LOAD without capturing.
  assign load_go = (state_q == S_LOAD) && (|bus.req);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake outputs. Requests take priority over refresh
  // expiry in IDLE; req and stray frame_done are ignored outside their states.
  always_comb begin
    state_d         = state_q;
    bus.ack         = 2'b00;
    bus.frame_start = 1'b0;
    bus.busy        = (state_q != S_IDLE);
    bus.dbg_state   = state_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req)
          state_d = S_LOAD;
        else if (held_valid_q && (refresh_cnt_q == REFRESH_LAST))
          state_d = S_START;
      end
      S_LOAD: begin
        if (load_go) begin
          bus.ack = winner ? 2'b10 : 2'b01;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        bus.frame_start = 1'b1;
        state_d         = S_SEND;
      end
      S_SEND: begin
        if (bus.frame_done) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_q       <= '0;
      owner_q       <= 1'b0;
      rr_q          <= 1'b0;
      held_valid_q  <= 1'b0;
      gap_cnt_q     <= '0;
      refresh_cnt_q <= '0;
    end else begin
      if (load_go) begin
        frame_q      <= winner ? bus.req_data1 : bus.req_data0;
        owner_q      <= winner;
        held_valid_q <= 1'b1;
        rr_q         <= ~winner;
      end

      if ((state_q == S_SEND) && bus.frame_done)
        gap_cnt_q <= '0;
      else if ((state_q == S_GAP) && (gap_cnt_q != GAP_LAST))
        gap_cnt_q <= gap_cnt_q + GW'(1);

      // Saturates so a long idle stretch before the first capture cannot wrap.
      if (state_q == S_START)
        refresh_cnt_q <= '0;
      else if ((state_q == S_IDLE) && (refresh_cnt_q != REFRESH_LAST))
        refresh_cnt_q <= refresh_cnt_q + RW'(1);
    end
  end

  assign bus.frame_data = frame_q;
  assign bus.cur_owner  = owner_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_led_frame_scheduler
// Drives two requesters and a serial-driver stand-in; a timing-level model
// predicts ack, frame_start, busy, frame_data and cur_owner every cycle.
// ----------------------------------------------------------------------------
module tb_led_frame_scheduler;
  localparam int NUM_LEDS = 6;
  localparam int FW       = 24 * NUM_LEDS;
  localparam int GAP      = 10;
  localparam int REF      = 100;
  localparam int INF      = 32'h7fff_ffff;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  int   cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  led_frame_scheduler_if #(.NUM_LEDS(NUM_LEDS)) bus ();

  led_frame_scheduler #(
    .NUM_LEDS      (NUM_LEDS),
    .GAP_CYCLES    (GAP),
    .REFRESH_CYCLES(REF)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver stand-in ----------------
  int done_len       = 8;
  int done_at        = -1;
  int stray_at       = -1;
  int drv_last_done  = -1;

  initial begin
    bus.frame_done = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sys_rst) begin
        done_at        = -1;
        bus.frame_done = 1'b0;
      end else begin
        if (bus.frame_start) done_at = cyc + done_len;
        bus.frame_done = (cyc == done_at) || (cyc == stray_at);
        if (cyc == done_at) drv_last_done = cyc;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  logic [FW-1:0] exp_q[$];       // frames accepted, awaiting their start
  int            m_idle_from;    // first cycle the scheduler is idle
  int            m_ack_cyc;
  int            m_start_cyc;
  logic [1:0]    m_ack_bits;
  logic          m_in_send;
  logic          m_held;
  logic          m_rr;
  logic [FW-1:0] m_frame;
  logic          m_owner;
  logic          m_pend_owner;
  logic [1:0]    e_ack;
  logic          e_start, e_busy, w;

  int         mon_start_cnt = 0;
  int         mon_last_start_cyc = -1;
  int         mon_ack_cnt = 0;
  int         mon_last_ack_cyc = -1;
  logic [1:0] mon_last_ack_bits = 2'b00;
  logic [1:0] mon_ack_last = 2'b00;

  always @(negedge sys_clk) begin
    mon_ack_last = bus.ack;
    if (bus.frame_start === 1'b1) begin
      mon_start_cnt++;
      mon_last_start_cyc = cyc;
    end
    if (bus.ack != 2'b00) begin
      mon_ack_cnt++;
      mon_last_ack_cyc  = cyc;
      mon_last_ack_bits = bus.ack;
    end

    if (sys_rst) begin
      exp_q.delete();
      m_idle_from  = cyc + 1;
      m_ack_cyc    = -1;
      m_start_cyc  = -1;
      m_ack_bits   = 2'b00;
      m_in_send    = 1'b0;
      m_held       = 1'b0;
      m_rr         = 1'b0;
      m_frame      = '0;
      m_owner      = 1'b0;
      m_pend_owner = 1'b0;
      chk("rst_ack",        FW'(bus.ack),         '0);
      chk("rst_frame_start", FW'(bus.frame_start), '0);
      chk("rst_busy",       FW'(bus.busy),        '0);
      chk("rst_frame_data", bus.frame_data,       '0);
      chk("rst_cur_owner",  FW'(bus.cur_owner),   '0);
    end else begin
      // An accepted frame becomes visible on its start cycle.
      if ((cyc == m_ack_cyc + 1) && (exp_q.size() != 0)) begin
        m_frame = exp_q.pop_front();
        m_owner = m_pend_owner;
      end
      e_ack   = (cyc == m_ack_cyc) ? m_ack_bits : 2'b00;
      e_start = (cyc == m_start_cyc);
      e_busy  = (cyc < m_idle_from);

      chk("ack",         FW'(bus.ack),         FW'(e_ack));
      chk("frame_start", FW'(bus.frame_start), FW'(e_start));
      chk("busy",        FW'(bus.busy),        FW'(e_busy));
      chk("frame_data",  bus.frame_data,       m_frame);
      chk("cur_owner",   FW'(bus.cur_owner),   FW'(m_owner));

      if (cyc == m_ack_cyc) m_held = 1'b1;
      if (m_in_send && bus.frame_done) begin
        m_in_send   = 1'b0;
        m_idle_from = cyc + 1 + GAP;
      end
      if (e_start) m_in_send = 1'b1;

      if (cyc >= m_idle_from) begin
        if (bus.req != 2'b00) begin
          w = (bus.req == 2'b11) ? m_rr : bus.req[1];
          exp_q.push_back(w ? bus.req_data1 : bus.req_data0);
          m_pend_owner = w;
          m_ack_bits   = w ? 2'b10 : 2'b01;
          m_ack_cyc    = cyc + 1;
          m_start_cyc  = cyc + 2;
          m_rr         = ~w;
          m_idle_from  = INF;
        end else if (m_held && (cyc - m_idle_from == REF - 1)) begin
          m_start_cyc = cyc + 1;
          m_idle_from = INF;
        end
      end
    end
  end

  // ---------------- requester driver tasks ----------------
  logic [1:0] dropped;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    dropped = bus.req & mon_ack_last;
    bus.req = bus.req & ~mon_ack_last;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < FW; k++) f[k] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic wait_start(input int budget);
    int s0;
    logic seen;
    s0   = mon_start_cnt;
    seen = 1'b0;
    for (int n = 0; (n < budget) && !seen; n++) begin
      tick();
      if (mon_start_cnt != s0) seen = 1'b1;
    end
    chk("wait_start_timeout", FW'(seen), FW'(1'b1));
  endtask

  // ---------------- main sequence ----------------
  logic [FW-1:0] f_a, f_b, last0;
  int r, acks0;

  initial begin
    sys_rst       = 1'b1;
    bus.req       = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_busy",        FW'(bus.busy),        '0);
    chk("reset_frame_start", FW'(bus.frame_start), '0);
    chk("reset_state",       FW'(bus.dbg_state),   '0);
    sys_rst = 1'b0;

    // Nothing may be sent before the first capture.
    repeat (1000) tick();
    chk("no_start_before_ack", FW'(mon_start_cnt), '0);

    // Single request from requester 0.
    f_a           = {NUM_LEDS{24'h00FF00}};
    done_len      = 8;
    tick();
    bus.req_data0 = f_a;
    bus.req       = 2'b01;
    r             = cyc;
    wait_start(20);
    chk("single_ack_cyc",   FW'(mon_last_ack_cyc),   FW'(r + 1));
    chk("single_ack_bits",  FW'(mon_last_ack_bits),  FW'(2'b01));
    chk("single_start_cyc", FW'(mon_last_start_cyc), FW'(r + 2));
    chk("single_frame",     bus.frame_data,          f_a);
    chk("single_owner",     FW'(bus.cur_owner),      '0);
    chk("single_busy",      FW'(bus.busy),           FW'(1'b1));

    // Tie raised mid-SEND: held off until done + gap, requester 1 favoured.
    tick();
    f_a = rand_frame();
    f_b = rand_frame();
    bus.req_data0 = f_a;
    bus.req_data1 = f_b;
    bus.req       = 2'b11;
    wait_start(100);
    chk("tie1_ack_bits",  FW'(mon_last_ack_bits),  FW'(2'b10));
    chk("tie1_ack_cyc",   FW'(mon_last_ack_cyc),   FW'(drv_last_done + 1 + GAP + 1));
    chk("tie1_start_cyc", FW'(mon_last_start_cyc), FW'(drv_last_done + 1 + GAP + 2));
    chk("tie1_frame",     bus.frame_data,          f_b);
    chk("tie1_owner",     FW'(bus.cur_owner),      FW'(1'b1));
    wait_start(100);
    chk("tie2_ack_bits",  FW'(mon_last_ack_bits),  FW'(2'b01));
    chk("tie2_start_cyc", FW'(mon_last_start_cyc), FW'(drv_last_done + 1 + GAP + 2));
    chk("tie2_frame",     bus.frame_data,          f_a);
    last0 = f_a;

    // Repeated ties keep alternating 1 then 0.
    for (int k = 0; k < 3; k++) begin
      f_a = rand_frame();
      f_b = rand_frame();
      bus.req_data0 = f_a;
      bus.req_data1 = f_b;
      bus.req       = 2'b11;
      wait_start(100);
      chk("rr_first_bits",  FW'(mon_last_ack_bits), FW'(2'b10));
      chk("rr_first_frame", bus.frame_data,         f_b);
      wait_start(100);
      chk("rr_second_bits", FW'(mon_last_ack_bits), FW'(2'b01));
      last0 = f_a;
    end

    // Auto refresh of the held frame, twice, with no new ack.
    acks0 = mon_ack_cnt;
    for (int k = 0; k < 2; k++) begin
      wait_start(300);
      chk("refresh_start_cyc", FW'(mon_last_start_cyc), FW'(drv_last_done + 1 + GAP + REF));
      chk("refresh_frame",     bus.frame_data,          last0);
      chk("refresh_owner",     FW'(bus.cur_owner),      '0);
      chk("refresh_no_ack",    FW'(mon_ack_cnt),        FW'(acks0));
    end

    // Async reset in the middle of SEND.
    done_len      = 50;
    f_a           = rand_frame();
    bus.req_data0 = f_a;
    bus.req       = 2'b01;
    wait_start(100);
    tick();
    tick();
    sys_rst = 1'b1;
    #1;
    chk("async_busy",        FW'(bus.busy),        '0);
    chk("async_frame_start", FW'(bus.frame_start), '0);
    chk("async_ack",         FW'(bus.ack),         '0);
    chk("async_frame_data",  bus.frame_data,       '0);
    chk("async_owner",       FW'(bus.cur_owner),   '0);
    chk("async_state",       FW'(bus.dbg_state),   '0);
    tick();
    tick();
    stray_at = cyc + 2;
    tick();
    sys_rst  = 1'b0;
    acks0    = mon_start_cnt;
    repeat (300) tick();
    chk("post_reset_no_start", FW'(mon_start_cnt), FW'(acks0));
    done_len      = 8;
    f_b           = rand_frame();
    bus.req_data1 = f_b;
    bus.req       = 2'b10;
    r             = cyc;
    wait_start(20);
    chk("post_reset_ack_cyc",   FW'(mon_last_ack_cyc),   FW'(r + 1));
    chk("post_reset_ack_bits",  FW'(mon_last_ack_bits),  FW'(2'b10));
    chk("post_reset_start_cyc", FW'(mon_last_start_cyc), FW'(r + 2));
    chk("post_reset_frame",     bus.frame_data,          f_b);
    chk("post_reset_owner",     FW'(bus.cur_owner),      FW'(1'b1));

    // Randomized traffic: busy phase, then sparse phase so refreshes occur.
    for (int n = 0; n < 5000; n++) begin
      tick();
      done_len = $urandom_range(1, 25);
      for (int i = 0; i < 2; i++) begin
        if (!bus.req[i] && !dropped[i] &&
            ($urandom_range(0, (n < 2500) ? 9 : 249) == 0)) begin
          if (i == 0) bus.req_data0 = rand_frame();
          else        bus.req_data1 = rand_frame();
          bus.req[i] = 1'b1;
        end
      end
      if (!bus.busy && ($urandom_range(0, 15) == 0)) stray_at = cyc + 1;
    end
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Sequences the 6-LED serial RGB chain driver. Two requesters (0 = game renderer, 1 = gesture status overlay) each submit a complete 144-bit frame. The block arbitrates between them round-robin and latches the winning frame. It then hands the frame to the serial driver with a start/done handshake and enforces the latch (reset) gap between frames. When no requester is active, it re-sends the last frame periodically so the chain recovers from glitches.

Parameters:
NUM_LEDS, 6, LEDs in chain; frame width FW = 24*NUM_LEDS (144 at default)
GAP_CYCLES, 2500, minimum idle sys_clk cycles after driver done before next start (50 us at 50 MHz)
REFRESH_CYCLES, 1000000, idle cycles after the previous start before an automatic re-send of the held frame (20 ms at 50 MHz)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
req  in  2  frame request per requester; held high until ack
req_data0  in  FW  frame from requester 0; bits [24k+23:24k] = LED k, GRB order
req_data1  in  FW  frame from requester 1, same layout
ack  out  2  one-cycle pulse; bit i = frame i captured
frame_data  out  FW  frame presented to driver; stable from start until done
frame_start  out  1  one-cycle pulse to driver
frame_done  in  1  one-cycle pulse from driver when last bit shifted
busy  out  1  high in any state other than IDLE
cur_owner  out  1  source of the frame currently held (0/1)

Behaviour:
- Reset (async, any state): state=IDLE; frame_data=0; ack=0; frame_start=0; busy=0; cur_owner=0; rr pointer=0 (requester 0 favoured first); gap and refresh counters=0; held_valid=0.
- States: IDLE, LOAD, START, SEND, GAP.
- IDLE: if any req bit is set, go to LOAD. Otherwise, if held_valid and refresh counter == REFRESH_CYCLES-1, go to START without reloading (re-send). The refresh counter increments only in IDLE and clears on every frame_start.
- LOAD (1 cycle): the winner is the only asserting requester, or the rr-favoured one if both assert.
  - frame_data <= winner data; cur_owner <= winner; ack[winner] pulses this cycle; held_valid <= 1.
  - rr pointer <= ~winner, so the loser wins the next tie.
  - Next state is START.
- START (1 cycle): frame_start=1, then SEND. Latency from req rising in IDLE to frame_start is 2 cycles.
- SEND: wait for frame_done. frame_data must not change. req is ignored in this state; requests stay pending, with no ack and no loss.
- GAP: on frame_done, load the gap counter with 0 and count to GAP_CYCLES-1, then go to IDLE. A pending req is serviced only after the gap completes, so back-to-back frames have start spacing ≥ driver time + GAP_CYCLES + 3.
- frame_done outside SEND is ignored.
- A req dropped before ack is simply not serviced; there is no error.
- If req stays high after ack, it counts as a new request (a new frame) at the next IDLE. Requesters must drop req the cycle after ack.
- Counters are sized with $clog2 of their parameter and must never wrap in normal operation. The refresh counter saturates at its terminal value.
- Simultaneous refresh expiry and req in IDLE: req wins, and the refresh counter clears on the resulting start.
- No frame is ever sent before the first ack, because held_valid=0 suppresses refresh.

Test Plan:
- Reset then single request: req=2'b01 with req_data0=144'h00FF00 repeated → ack=01 at cycle 1, frame_start at cycle 2, frame_data=req_data0, cur_owner=0, busy=1 until the gap ends.
- Tie and round-robin: req=2'b11 held, with each requester dropping its own bit after ack → first ack=01, second ack=10 after done+GAP_CYCLES. Repeating this yields strict alternation.
- Request during SEND: req1 rises mid-SEND → no ack until frame_done + GAP_CYCLES. frame_data is unchanged through SEND. Then ack=10 and the next start follows 2 cycles later.
- Gap timing (GAP_CYCLES=10 in the bench): done at cycle T with req pending → next frame_start exactly at T+1+10+2.
- Auto refresh (REFRESH_CYCLES=100): one frame, then idle → frame_start repeats with identical frame_data and no ack. Before the first ack, no frame_start appears for 1000 cycles.
- Async reset asserted mid-SEND → all outputs immediately 0 and state IDLE. A stray frame_done after release is ignored, and the next req is serviced normally.
